// File: rtl/mole_hit_if.sv
// Player-side bundle between the button/mole sources and mole_hit_detector.
// The slave modport is the detector's view; the master modport is the driver's view.
interface mole_hit_if #(
  parameter int NUM_HOLES = 4,
  parameter int IDX_W     = 2
);
  logic                 game_active;
  logic                 tick_1ms;
  logic [NUM_HOLES-1:0] buttons;
  logic                 mole_valid;
  logic [IDX_W-1:0]     mole_idx;
  logic                 player_scored;
  logic                 mole_clear;
  logic                 wrong_press;
  logic [7:0]           miss_count;

  modport master (
    output game_active, tick_1ms, buttons, mole_valid, mole_idx,
    input  player_scored, mole_clear, wrong_press, miss_count
  );

  modport slave (
    input  game_active, tick_1ms, buttons, mole_valid, mole_idx,
    output player_scored, mole_clear, wrong_press, miss_count
  );
endinterface

// File: rtl/mole_hit_detector.sv
// Turns synchronized button edges plus the active-mole report into hit/miss pulses,
// with a tick-timed lockout after each hit and a saturating miss counter.
//
// state     | meaning
// IDLE      | game not running, outputs and miss count held at 0
// WAIT_MOLE | no valid mole up, any press is a miss
// ARMED     | valid mole up, single correct press scores
// COOLDOWN  | post-hit lockout, presses ignored until LOCKOUT_TICKS ticks
module mole_hit_detector #(
  parameter int NUM_HOLES     = 4,
  parameter int IDX_W         = 2,
  parameter int LOCKOUT_TICKS = 200
) (
  input  logic       clkIn,
  input  logic       reset,
  mole_hit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MOLE, ARMED, COOLDOWN} state_t;

  localparam logic [IDX_W:0] HOLES_LIM = (IDX_W+1)'(NUM_HOLES);
  localparam logic [9:0]     LOCK_TC   = 10'(LOCKOUT_TICKS);

  state_t               state_q;
  logic [NUM_HOLES-1:0] s1_q, s2_q, s3_q;
  logic [9:0]           lock_cnt_q;
  logic                 scored_q, wrong_q;
  logic [7:0]           miss_q;

  logic [NUM_HOLES-1:0] edge_d, hit_mask_d;
  logic                 mole_ok_d, any_edge_d;
  logic [7:0]           miss_inc_d;

  always_comb begin
    mole_ok_d  = bus.mole_valid & ({1'b0, bus.mole_idx} < HOLES_LIM);
    edge_d     = s2_q & ~s3_q;
    any_edge_d = |edge_d;
    hit_mask_d = {{(NUM_HOLES-1){1'b0}}, 1'b1} << bus.mole_idx;
    miss_inc_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
  end

  // Conditioning runs in every state so a button held at game start has no edge.
  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= bus.buttons;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      scored_q   <= 1'b0;
      wrong_q    <= 1'b0;
      miss_q     <= '0;
    end else begin
      scored_q <= 1'b0;
      wrong_q  <= 1'b0;
      if (!bus.game_active) begin
        state_q <= IDLE;
        miss_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            miss_q  <= '0;
            state_q <= WAIT_MOLE;
          end
          WAIT_MOLE: begin
            if (any_edge_d) begin
              wrong_q <= 1'b1;
              miss_q  <= miss_inc_d;
            end
            if (mole_ok_d) state_q <= ARMED;
          end
          ARMED: begin
            // A mole that vanishes is not a miss, but a press with no mole still is.
            if (!mole_ok_d) begin
              state_q <= WAIT_MOLE;
              if (any_edge_d) begin
                wrong_q <= 1'b1;
                miss_q  <= miss_inc_d;
              end
            end else if (edge_d == hit_mask_d) begin
              scored_q   <= 1'b1;
              lock_cnt_q <= '0;
              state_q    <= COOLDOWN;
            end else if (any_edge_d) begin
              wrong_q <= 1'b1;
              miss_q  <= miss_inc_d;
            end
          end
          COOLDOWN: begin
            if (bus.tick_1ms) begin
              lock_cnt_q <= lock_cnt_q + 10'd1;
              if (lock_cnt_q + 10'd1 == LOCK_TC) state_q <= WAIT_MOLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.player_scored = scored_q;
  assign bus.mole_clear    = scored_q;
  assign bus.wrong_press   = wrong_q;
  assign bus.miss_count    = miss_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Scoreboard bench for mole_hit_detector: each press pushes its expected pulse,
// a negedge monitor pops and compares every pulse the detector produces.
module tb_mole_hit_detector;

  localparam int NH = 4;
  localparam int IW = 3;

  typedef struct {
    int         cyc;
    logic       sc;
    logic       wr;
    logic [7:0] miss;
  } ev_t;

  logic clkIn = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_miss = 0;
  logic prev_sc  = 1'b0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  mole_hit_if #(.NUM_HOLES(NH), .IDX_W(IW)) bus ();

  mole_hit_detector #(.NUM_HOLES(NH), .IDX_W(IW), .LOCKOUT_TICKS(200)) dut (
    .clkIn (clkIn),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // kind: 0 = no pulse expected, 1 = score, 2 = wrong press
  task automatic press(input logic [NH-1:0] v, input int hold, input int kind);
    ev_t e;
    @(negedge clkIn);
    bus.buttons = v;
    if (kind != 0) begin
      e.cyc = cyc + 3;
      e.sc  = (kind == 1);
      e.wr  = (kind == 2);
      if (kind == 2 && exp_miss < 255) exp_miss++;
      e.miss = 8'(exp_miss);
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge clkIn);
    bus.buttons = '0;
    repeat (4) @(negedge clkIn);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      @(negedge clkIn);
      bus.tick_1ms = 1'b1;
      @(negedge clkIn);
      bus.tick_1ms = 1'b0;
      @(negedge clkIn);
    end
  endtask

  task automatic settle(input string tag);
    repeat (6) @(negedge clkIn);
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clkIn) begin
    if (bus.player_scored || bus.mole_clear || bus.wrong_press) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bus.player_scored, bus.mole_clear, bus.wrong_press}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("player_scored", bus.player_scored, mon_e.sc);
        chk("mole_clear", bus.mole_clear, mon_e.sc);
        chk("wrong_press", bus.wrong_press, mon_e.wr);
        chk("pulse_cycle", cyc, mon_e.cyc);
        chk("miss_count", bus.miss_count, mon_e.miss);
      end
      if (bus.player_scored) chk("back_to_back_score", prev_sc, 0);
    end
    prev_sc = bus.player_scored;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.game_active = 1'b1;
    bus.tick_1ms    = 1'b0;
    bus.buttons     = '0;
    bus.mole_valid  = 1'b1;
    bus.mole_idx    = 3'd2;

    // Reset held low, outputs must be clear.
    repeat (5) @(negedge clkIn);
    chk("rst_scored", bus.player_scored, 0);
    chk("rst_clear", bus.mole_clear, 0);
    chk("rst_wrong", bus.wrong_press, 0);
    chk("rst_miss", bus.miss_count, 0);
    reset = 1'b1;
    repeat (4) @(negedge clkIn);

    // Basic hit on hole 2.
    press(4'b0100, 3, 1);
    settle("pending_hit");

    // Lockout: presses ignored, 199 ticks not enough, 200th releases it.
    run_ticks(50);
    press(4'b0100, 3, 0);
    run_ticks(100);
    press(4'b0100, 3, 0);
    run_ticks(49);
    press(4'b0100, 2, 0);
    settle("pending_lockout");
    run_ticks(1);
    press(4'b0100, 2, 1);
    settle("pending_after_lockout");

    // Anti-mash: correct button plus another is a single miss.
    bus.mole_idx = 3'd1;
    run_ticks(200);
    press(4'b0011, 2, 2);
    press(4'b0010, 2, 1);
    settle("pending_mash");
    run_ticks(200);

    // Button held across game start gives no edge; long hold scores once.
    @(negedge clkIn);
    bus.game_active = 1'b0;
    exp_miss = 0;
    bus.mole_idx = 3'd3;
    bus.buttons = 4'b1000;
    repeat (5) @(negedge clkIn);
    bus.game_active = 1'b1;
    repeat (10) @(negedge clkIn);
    bus.buttons = '0;
    repeat (4) @(negedge clkIn);
    chk("held_no_score_pending", exp_q.size(), 0);
    press(4'b1000, 1000, 1);
    settle("pending_long_hold");

    // Saturation of the miss counter in WAIT_MOLE.
    @(negedge clkIn);
    bus.game_active = 1'b0;
    bus.mole_valid  = 1'b0;
    repeat (3) @(negedge clkIn);
    bus.game_active = 1'b1;
    repeat (3) @(negedge clkIn);
    for (int i = 0; i < 300; i++) press(4'b0001, 1, 2);
    settle("pending_sat");
    chk("miss_saturated", bus.miss_count, 255);

    // Dropping game_active clears miss count next cycle and silences presses.
    @(negedge clkIn);
    bus.game_active = 1'b0;
    exp_miss = 0;
    @(negedge clkIn);
    chk("miss_clr_on_idle", bus.miss_count, 0);
    press(4'b0001, 2, 0);
    press(4'b0110, 2, 0);
    settle("pending_idle");
    chk("miss_idle_held", bus.miss_count, 0);

    // Out-of-range index is no mole.
    bus.mole_valid  = 1'b1;
    bus.mole_idx    = 3'd5;
    bus.game_active = 1'b1;
    repeat (4) @(negedge clkIn);
    press(4'b0001, 2, 2);
    press(4'b0100, 2, 2);
    settle("pending_oor");
    bus.mole_idx = 3'd0;
    repeat (3) @(negedge clkIn);
    press(4'b0001, 2, 1);
    settle("pending_oor_hit");

    // Asynchronous reset in the middle of the lockout.
    run_ticks(50);
    @(negedge clkIn);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_miss", bus.miss_count, 0);
    chk("async_rst_scored", bus.player_scored, 0);
    chk("async_rst_wrong", bus.wrong_press, 0);
    exp_miss = 0;
    repeat (3) @(negedge clkIn);
    reset = 1'b1;
    repeat (4) @(negedge clkIn);
    press(4'b0001, 2, 1);
    settle("pending_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
